// File: rtl/spike_event_fifo.sv
// spike_event_fifo
// Samples the LIF neuron's spike/state every clock, tags each spike event with a
// free-running timestamp, buffers events in a small first-word fall-through FIFO
// and presents them on a valid/ready port. Events arriving while the FIFO is full
// (and the head is not being popped) are dropped and counted.
module spike_event_fifo #(
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 8,
  parameter int EDGE_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       spike,
  input  logic [7:0]                 state,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [TS_WIDTH-1:0]        ev_timestamp,
  output logic [7:0]                 ev_state,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_count,
  input  logic                       clear_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // registered state
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                spike_prev_q, spike_prev_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_count_q, drop_count_d;
  logic [TS_WIDTH-1:0] head_ts_q, head_ts_d;
  logic [7:0]          head_state_q, head_state_d;
  logic [TS_WIDTH-1:0] ts_mem_q [DEPTH];
  logic [TS_WIDTH-1:0] ts_mem_d [DEPTH];
  logic [7:0]          st_mem_q [DEPTH];
  logic [7:0]          st_mem_d [DEPTH];

  // handshake / event qualifiers
  logic fire;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Event detection and FIFO push/pop/drop decisions.
  always_comb begin
    fire  = en & spike & ((EDGE_MODE != 0) ? ~spike_prev_q : 1'b1);
    empty = (level_q == '0);
    full  = (level_q == LW'(DEPTH));
    pop   = ~empty & ev_ready;
    // A full FIFO still accepts an event when the head leaves in the same cycle.
    push  = fire & (~full | pop);
    drop  = fire & full & ~pop;
  end

  // Timestamp, edge detector, pointers and occupancy.
  always_comb begin
    ts_d         = en ? ts_q + TS_WIDTH'(1) : ts_q;
    spike_prev_d = spike;
    wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d      = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  // Storage write.
  always_comb begin
    ts_mem_d = ts_mem_q;
    st_mem_d = st_mem_q;
    if (push) begin
      ts_mem_d[wr_ptr_q] = ts_q;
      st_mem_d[wr_ptr_q] = state;
    end
  end

  // Next head register: the entry that will sit at rd_ptr after this edge.
  // It is the event being written now when the write slot equals the new read
  // slot (FIFO was empty, or held one entry that is being popped); otherwise
  // it is already in storage. With nothing left the last head is held.
  always_comb begin
    head_ts_d    = head_ts_q;
    head_state_d = head_state_q;
    if (level_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        head_ts_d    = ts_q;
        head_state_d = state;
      end else begin
        head_ts_d    = ts_mem_q[rd_ptr_d];
        head_state_d = st_mem_q[rd_ptr_d];
      end
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop in the clearing
  // cycle is counted as the first drop after the clear.
  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clear_overflow) begin
      overflow_d   = drop;
      drop_count_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) begin
        drop_count_d = drop_count_q + 8'd1;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q         <= '0;
      spike_prev_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      head_ts_q    <= '0;
      head_state_q <= '0;
    end else begin
      ts_q         <= ts_d;
      spike_prev_q <= spike_prev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      head_ts_q    <= head_ts_d;
      head_state_q <= head_state_d;
    end
  end

  // Event storage; cleared on reset so no stale data can ever surface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ts_mem_q[i] <= '0;
        st_mem_q[i] <= '0;
      end
    end else begin
      ts_mem_q <= ts_mem_d;
      st_mem_q <= st_mem_d;
    end
  end

  // Outputs come straight from registers; ev_ready has no combinational path out.
  assign ev_valid     = (level_q != '0);
  assign ev_timestamp = head_ts_q;
  assign ev_state     = head_state_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign drop_count   = drop_count_q;

endmodule

// File: doc/spike_event_fifo.md
Name: spike_event_fifo

Overview:
- Sits directly downstream of the LIF neuron.
- Samples the neuron's spike and 8-bit membrane state each clock and tags each spike event with a free-running timestamp.
- Buffers events in a small FIFO and presents them to a consumer (readout/serializer) over a valid/ready interface.
- Counts events lost to back-pressure.

Parameters:
- TS_WIDTH, 16, width of timestamp counter and event timestamp field.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- EDGE_MODE, 1, 1 = one event per rising edge of spike; 0 = one event per cycle spike is high.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable; also gates the timestamp counter
- spike  input  1  neuron spike level
- state  input  8  neuron membrane state, captured with each event
- ev_valid  output  1  head event available
- ev_ready  input  1  consumer accepts head event when ev_valid & ev_ready
- ev_timestamp  output  TS_WIDTH  timestamp of head event
- ev_state  output  8  membrane state of head event
- level  output  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky, set when an event is dropped
- drop_count  output  8  saturating count of dropped events
- clear_overflow  input  1  synchronous clear of overflow and drop_count

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - ts counter 0, spike_prev 0, FIFO empty (rd_ptr = wr_ptr = 0).
  - ev_valid 0, ev_timestamp 0, ev_state 0, level 0, overflow 0, drop_count 0.
- Timestamp:
  - ts increments by 1 on each clock with en = 1, wrapping from 2^TS_WIDTH-1 to 0.
  - ts holds when en = 0.
- Edge detect: spike_prev <= spike every clock, regardless of en.
- Event generation:
  - fire = en & spike & (EDGE_MODE ? ~spike_prev : 1).
  - The event captures {ts (pre-increment value), state} sampled at that edge.
- Push: on fire, if not full, write the event at wr_ptr and advance wr_ptr.
- Latency: an event sampled at edge N makes ev_valid high after edge N when the FIFO was empty (one-cycle latency).
- Output mode: first-word fall-through. ev_timestamp and ev_state always show the entry at rd_ptr while ev_valid = 1, and hold their last value when the FIFO is empty.
- Pop: on ev_valid & ev_ready, advance rd_ptr.
- ev_ready while ev_valid = 0 is ignored.
- Handshake rules:
  - ev_valid, once high, stays high with a stable head until the head is popped.
  - The head is never overwritten.
- Occupancy: level = number of stored entries, 0..DEPTH. full = (level == DEPTH), empty = (level == 0). Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Push and pop in the same cycle:
  - Not full: both occur and level is unchanged.
  - Full with pop: both occur; the new event is accepted into the freed slot, level stays DEPTH, nothing is dropped.
  - Empty: no pop occurs (ev_valid = 0); the push occurs and level becomes 1.
- Drop: fire while full and no pop in the same cycle.
  - The event is discarded and the FIFO is unchanged.
  - overflow <= 1.
  - drop_count increments, saturating at 255.
- clear_overflow: next edge overflow <= 0 and drop_count <= 0.
  - If a drop occurs in the same cycle: overflow <= 1, drop_count <= 1.
- Reset mid-operation: all contents are discarded immediately and outputs return to their reset values asynchronously. In-flight handshakes are abandoned; the consumer must not expect an event after reset.
- No combinational path from ev_ready to ev_valid, ev_timestamp or ev_state. ev_valid is a function of registered state only.

Test Plan:
- Reset, en = 1, EDGE_MODE = 1, ev_ready = 1, spike high at cycles 5-7 with state = 210 -> exactly one event: ev_timestamp = 5, ev_state = 210, ev_valid high one cycle after cycle 5; level returns to 0.
- EDGE_MODE = 0, spike high at cycles 10-12 with state = 200, 201, 202, ev_ready = 0 -> level = 3; then ev_ready = 1 pops in order (10, 200), (11, 201), (12, 202).
- DEPTH = 8, ev_ready = 0, 10 distinct spike pulses -> level = 8, overflow = 1, drop_count = 2; the 8 oldest events are retained in order.
- FIFO full, ev_ready = 1 and a new spike edge in the same cycle -> level stays 8, drop_count unchanged, the new event lands at the tail.
- Drop and clear_overflow in the same cycle with drop_count = 5 -> overflow = 1, drop_count = 1. A clear alone next cycle -> 0, 0.
- en = 0 for 20 cycles with spikes present -> no events and ts frozen; re-enable -> next event timestamp continues from the frozen value.
- With TS_WIDTH = 4 -> the timestamp wraps 15 -> 0.
- Assert rst_n low with 3 events queued -> ev_valid = 0 and level = 0 immediately.
